reduce_gate_pipe: RTL and testbench
===================================

# reduce_gate_pipe

Parametrised, pipelined N-input logic reduction unit; successor to the fixed 3-input AND gate. It reduces a WIDTH-bit operand vector to one bit under a per-transaction selectable mode (AND/OR/XOR and their inversions). The reduction is a registered binary tree with valid/ready flow control, so it can sit directly in a streaming datapath between registered producers and consumers.

## Interface
- WIDTH, 8, operand bit count; legal range 2..64.
- STAGES, $clog2(WIDTH), derived localparam: number of registered tree levels. Not user-overridable.
- Clk  input  1  rising-edge clock.
- Rst  input  1  reset, asynchronous, active-high.
- InValid  input  1  operand/mode present.
- InReady  output  1  block accepts this cycle.
- A  input  WIDTH  operand vector.
- Mode  input  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6–7 reserved.
- OutValid  output  1  result present.
- OutReady  input  1  consumer accepts this cycle.
- Out  output  1  reduction result.
- ModeErr  output  1  result came from a reserved Mode.
- CntClr  input  1  (REDUCE_GATE_STATS_EN only) synchronous clear of OnesCount.
- OnesCount  output  16  (REDUCE_GATE_STATS_EN only) count of accepted results with Out=1.

## Operation
- Input accepted when InValid && InReady. Mode is captured with A and travels with it down the pipeline.
- Level 0 pads A to 2^STAGES bits with the mode identity: 1 for AND/NAND, 0 for OR/NOR/XOR/XNOR.
- Each level combines adjacent pairs with the base operator (AND, OR or XOR) and registers the result. The base operator ignores inversion.
- After the last level, NAND/NOR/XNOR invert the result.
- Reserved Mode: Out=0 and ModeErr=1 for that transaction. ModeErr=0 otherwise.
- Flow control:
  - advance = OutReady || !OutValid.
  - InReady = advance (combinational path from OutReady; this is accepted).
  - When advance=1, all stage valid and data registers shift one level. A level-0 valid bit is loaded from InValid.
  - When advance=0, every stage holds.
  - Bubbles collapse only when the output stage is empty.
- While OutValid && !OutReady, Out, ModeErr and OutValid hold stable.
- Reset:
  - All valid bits 0, all data registers 0.
  - Out=0, ModeErr=0, OutValid=0, OnesCount=0.
  - InReady reads 1 during and after reset.
- Reset mid-operation discards all in-flight transactions. There is no partial output.

## Timing
- Latency STAGES cycles from input acceptance to OutValid with no stall (WIDTH=8: 3; WIDTH=5: 3; WIDTH=2: 1).
- Throughput one result per cycle when OutReady is held high.
- Acceptance and output handshake in the same cycle are legal. The pipeline shifts and the new item enters level 0.
- InValid may drop at any cycle. An empty slot propagates as a bubble.

## Configuration
- REDUCE_GATE_STATS_EN defined:
  - Adds the CntClr and OnesCount ports.
  - OnesCount increments on each output handshake (OutValid && OutReady) with Out=1, and saturates at 16'hFFFF.
  - CntClr wins over a same-cycle increment.
  - Cleared by Rst.
- REDUCE_GATE_STATS_EN undefined: ports and counter are absent; all other behaviour is identical.

## Structure
- Package reduce_gate_pkg holds:
  - the mode enum (MODE_AND … MODE_XNOR);
  - an identity-value function;
  - a base-operator select function;
  - an is-inverting function.
- Sub-module reduce_gate_stage is one tree level: pairwise combine plus valid/data/mode register with hold on !advance. It is instantiated STAGES times via generate.

## Test plan
- WIDTH=8, Mode=0, A=8'hFF then 8'hFE, OutReady=1:
  - Out=1 at acceptance+3 cycles, then Out=0 the next cycle.
  - ModeErr=0 on both.
- WIDTH=5, Mode=3 (NAND), A=5'h1F, then Mode=2 (XOR), A=5'h07:
  - Out=0, then Out=1.
  - Padding identity is verified.
- Back-to-back stream of 10 items with OutReady=0 for cycles 4–7:
  - InReady=0 during the stall; Out and ModeErr are held stable.
  - No item is lost or duplicated; order is preserved.
- Mode=6, A=8'hFF: Out=0, ModeErr=1 after 3 cycles.
- Rst asserted while 3 items are in flight:
  - OutValid=0 and Out=0 immediately (asynchronous).
  - After release, no stale result appears.
- With REDUCE_GATE_STATS_EN:
  - 5 accepted Out=1 results give OnesCount=5.
  - CntClr pulsed on the same cycle as a sixth Out=1 handshake gives OnesCount=0.

Source files
------------

// File: rtl/reduce_gate_pkg.sv
// reduce_gate_pkg: mode encoding and per-mode helpers shared by the
// reduction tree levels and the pipeline top.
package reduce_gate_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2
  } op_e;

  // Modes 6 and 7 have no defined reduction.
  function automatic logic is_reserved(input logic [2:0] m);
    return (m > 3'(MODE_XNOR));
  endfunction

  // Value that leaves the base operator unchanged; used to pad the operand.
  function automatic logic identity(input logic [2:0] m);
    return (m == 3'(MODE_AND)) || (m == 3'(MODE_NAND));
  endfunction

  // Base operator with the inversion stripped off.
  function automatic op_e base_op(input logic [2:0] m);
    case (m)
      3'(MODE_AND), 3'(MODE_NAND): return OP_AND;
      3'(MODE_XOR), 3'(MODE_XNOR): return OP_XOR;
      default:                     return OP_OR;
    endcase
  endfunction

  function automatic logic is_inverting(input logic [2:0] m);
    return (m == 3'(MODE_NAND)) || (m == 3'(MODE_NOR)) || (m == 3'(MODE_XNOR));
  endfunction

  function automatic logic combine(input op_e op, input logic x, input logic y);
    case (op)
      OP_AND:  return x & y;
      OP_XOR:  return x ^ y;
      default: return x | y;
    endcase
  endfunction

endpackage

// File: rtl/reduce_gate_stage.sv
// reduce_gate_stage: one registered level of the reduction tree. Combines
// adjacent bit pairs with the mode's base operator and registers the result
// together with the valid bit and mode; holds everything while !advance.
module reduce_gate_stage
  import reduce_gate_pkg::*;
#(
  parameter int unsigned IN_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  input  logic [2:0]        in_mode,
  output logic              out_valid,
  output logic [IN_W/2-1:0] out_data,
  output logic [2:0]        out_mode
);

  logic [IN_W/2-1:0] combined;

  // Pairwise combine of the incoming level.
  always_comb begin
    combined = '0;
    for (int unsigned i = 0; i < IN_W / 2; i++) begin
      combined[i] = combine(base_op(in_mode), in_data[2*i], in_data[2*i+1]);
    end
  end

  // Level register: shift on advance, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_data  <= combined;
      out_mode  <= in_mode;
    end
  end

endmodule

// File: rtl/reduce_gate_pipe.sv
// reduce_gate_pipe: pipelined WIDTH-input AND/OR/XOR (and inverted) reduction
// with valid/ready flow control. Optional statistics counter (CntClr,
// OnesCount) is built when REDUCE_GATE_STATS_EN is defined.
module reduce_gate_pipe
  import reduce_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       Mode,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Out,
  output logic             ModeErr
`ifdef REDUCE_GATE_STATS_EN
  ,
  input  logic             CntClr,
  output logic [15:0]      OnesCount
`endif
);

  localparam int unsigned STAGES = $clog2(WIDTH);
  localparam int unsigned PW     = 1 << STAGES;

  // All tree levels packed into one vector: level k starts at 2*PW - 2*(PW>>k)
  // and is PW>>k bits wide, so the final single bit sits at 2*PW-2.
  logic [2*PW-2:0] tree;
  logic [PW-1:0]   padded;
  logic [STAGES:0] vld;
  logic [2:0]      mode_l [0:STAGES];
  logic            advance;
  logic            last_bit;
  logic [2:0]      last_mode;

  assign advance  = OutReady || !OutValid;
  assign InReady  = advance;
  assign OutValid = vld[STAGES];

  // Level 0: operand padded up to a power of two with the mode identity.
  always_comb begin
    padded             = {PW{identity(Mode)}};
    padded[WIDTH-1:0]  = A;
  end

  assign tree[PW-1:0] = padded;
  assign vld[0]       = InValid;
  assign mode_l[0]    = Mode;

  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    localparam int unsigned IW      = PW >> k;
    localparam int unsigned OFF_IN  = 2*PW - 2*IW;
    localparam int unsigned OFF_OUT = OFF_IN + IW;

    reduce_gate_stage #(.IN_W(IW)) u_stage (
      .clk      (Clk),
      .rst      (Rst),
      .advance  (advance),
      .in_valid (vld[k]),
      .in_data  (tree[OFF_IN +: IW]),
      .in_mode  (mode_l[k]),
      .out_valid(vld[k+1]),
      .out_data (tree[OFF_OUT +: IW/2]),
      .out_mode (mode_l[k+1])
    );
  end

  assign last_bit  = tree[2*PW-2];
  assign last_mode = mode_l[STAGES];

  // Output mapping from the last registered level: inversion and reserved-mode flag.
  always_comb begin
    ModeErr = is_reserved(last_mode);
    Out     = ModeErr ? 1'b0 : (last_bit ^ is_inverting(last_mode));
  end

`ifdef REDUCE_GATE_STATS_EN
  // Saturating count of delivered results equal to 1; clear beats increment.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      OnesCount <= '0;
    end else if (CntClr) begin
      OnesCount <= '0;
    end else if (OutValid && OutReady && Out && (OnesCount != 16'hFFFF)) begin
      OnesCount <= OnesCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// tb_reduce_gate_pipe: directed bench for reduce_gate_pipe at WIDTH=8 and
// WIDTH=5, with a scoreboard of expected {ModeErr,Out} per accepted item.
module tb_reduce_gate_pipe;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst;
  logic       iv8, ir8, ov8, or8, o8, me8;
  logic [7:0] a8;
  logic [2:0] m8;
  logic       iv5, ir5, ov5, or5, o5, me5;
  logic [4:0] a5;
  logic [2:0] m5;
`ifdef REDUCE_GATE_STATS_EN
  logic        cc8, cc5;
  logic [15:0] oc8, oc5;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] q8[$];
  logic [1:0] q5[$];
  logic       hold8_prev = 1'b0;
  logic [1:0] hold8_val  = 2'b00;

  reduce_gate_pipe #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .InValid(iv8), .InReady(ir8), .A(a8), .Mode(m8),
    .OutValid(ov8), .OutReady(or8), .Out(o8), .ModeErr(me8)
`ifdef REDUCE_GATE_STATS_EN
    , .CntClr(cc8), .OnesCount(oc8)
`endif
  );

  reduce_gate_pipe #(.WIDTH(5)) dut5 (
    .Clk(Clk), .Rst(Rst), .InValid(iv5), .InReady(ir5), .A(a5), .Mode(m5),
    .OutValid(ov5), .OutReady(or5), .Out(o5), .ModeErr(me5)
`ifdef REDUCE_GATE_STATS_EN
    , .CntClr(cc5), .OnesCount(oc5)
`endif
  );

  // Reference: direct reduction over the w real bits, returns {err,out}.
  function automatic logic [1:0] model(input logic [63:0] a, input int unsigned w,
                                       input logic [2:0] m);
    logic r_and, r_or, r_xor;
    r_and = 1'b1; r_or = 1'b0; r_xor = 1'b0;
    for (int unsigned i = 0; i < w; i++) begin
      r_and = r_and & a[i];
      r_or  = r_or  | a[i];
      r_xor = r_xor ^ a[i];
    end
    case (m)
      3'd0:    return {1'b0, r_and};
      3'd1:    return {1'b0, r_or};
      3'd2:    return {1'b0, r_xor};
      3'd3:    return {1'b0, ~r_and};
      3'd4:    return {1'b0, ~r_or};
      3'd5:    return {1'b0, ~r_xor};
      default: return 2'b10;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q8.size() == 0 && q5.size() == 0) break;
      tick();
    end
    check("drain_empty", 32'(q8.size() + q5.size()), 32'd0);
  endtask

  task automatic send5(input logic [4:0] a, input logic [2:0] m);
    iv5 = 1'b1; a5 = a; m5 = m;
    tick();
    iv5 = 1'b0;
  endtask

  // Scoreboard and hold monitor for the WIDTH=8 instance.
  always @(negedge Clk) begin
    if (Rst) begin
      hold8_prev = 1'b0;
    end else begin
      if (hold8_prev) check("hold8", {29'd0, ov8, me8, o8}, {29'd0, 1'b1, hold8_val});
      hold8_prev = ov8 && !or8;
      hold8_val  = {me8, o8};
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          n_assert++; n_fail++;
          $error("FAIL sb8_unexpected: observed output %0b expected none", o8);
        end else begin
          check("sb8_result", {30'd0, me8, o8}, {30'd0, q8.pop_front()});
        end
      end
      if (iv8 && ir8) q8.push_back(model(64'(a8), 8, m8));
    end
  end

  // Scoreboard for the WIDTH=5 instance.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (ov5 && or5) begin
        if (q5.size() == 0) begin
          n_assert++; n_fail++;
          $error("FAIL sb5_unexpected: observed output %0b expected none", o5);
        end else begin
          check("sb5_result", {30'd0, me5, o5}, {30'd0, q5.pop_front()});
        end
      end
      if (iv5 && ir5) q5.push_back(model(64'(a5), 5, m5));
    end
  end

  logic [7:0] sa [10];
  logic [2:0] sm [10];
  int         idx;
  logic       got;

  initial begin
    iv8 = 0; a8 = '0; m8 = '0; or8 = 1;
    iv5 = 0; a5 = '0; m5 = '0; or5 = 1;
`ifdef REDUCE_GATE_STATS_EN
    cc8 = 0; cc5 = 0;
`endif
    Rst = 1'b1;
    #1;
    check("rst_inready", {31'd0, ir8}, 32'd1);
    check("rst_outvalid", {31'd0, ov8}, 32'd0);
    check("rst_out", {31'd0, o8}, 32'd0);
    check("rst_modeerr", {31'd0, me8}, 32'd0);
    check("rst_outvalid5", {31'd0, ov5}, 32'd0);
`ifdef REDUCE_GATE_STATS_EN
    check("rst_onescount", {16'd0, oc8}, 32'd0);
`endif
    tick(); tick();
    Rst = 1'b0;
    tick();

    // AND of FF then FE: latency of three cycles, then back-to-back.
    iv8 = 1; a8 = 8'hFF; m8 = 3'd0;
    tick();
    a8 = 8'hFE;
    tick();
    iv8 = 0;
    check("lat_not_yet", {31'd0, ov8}, 32'd0);
    tick();
    check("lat_valid", {31'd0, ov8}, 32'd1);
    check("and_ff", {30'd0, me8, o8}, 32'b01);
    tick();
    check("and_fe", {30'd0, me8, o8}, 32'b00);
    tick();
    check("bubble_after", {31'd0, ov8}, 32'd0);

    // WIDTH=5: padding identity for each mode family.
    send5(5'h1F, 3'd3);
    send5(5'h07, 3'd2);
    send5(5'h1F, 3'd0);
    send5(5'h1F, 3'd2);
    send5(5'h00, 3'd1);
    send5(5'h10, 3'd5);
    send5(5'h00, 3'd4);
    drain();

    // Reserved mode.
    iv8 = 1; a8 = 8'hFF; m8 = 3'd6;
    tick();
    iv8 = 0;
    tick();
    check("rsv_not_yet", {31'd0, ov8}, 32'd0);
    tick();
    check("rsv_result", {29'd0, ov8, me8, o8}, 32'b110);
    tick();

    // Stream of 10 items, consumer stalls for cycles 4..7.
    for (int i = 0; i < 10; i++) begin
      sa[i] = 8'($urandom);
      sm[i] = 3'($urandom_range(0, 7));
    end
    sm[0] = 3'd0; sa[0] = 8'hFF;
    sm[1] = 3'd1; sa[1] = 8'h00;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
      or8 = !(cyc >= 4 && cyc <= 7);
      iv8 = 1; a8 = sa[idx]; m8 = sm[idx];
      @(negedge Clk);
      if (!or8) check("stall_inready", {31'd0, ir8}, 32'd0);
      if (ir8) idx++;
      tick();
    end
    iv8 = 0; or8 = 1;
    check("stream_sent", 32'(idx), 32'd10);
    drain();

    // Reset with three items in flight.
    iv8 = 1; a8 = 8'hFF; m8 = 3'd0;
    tick(); tick(); tick();
    iv8 = 0;
    check("pre_rst_valid", {31'd0, ov8}, 32'd1);
    #1 Rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, ov8}, 32'd0);
    check("async_rst_out", {31'd0, o8}, 32'd0);
    check("async_rst_inready", {31'd0, ir8}, 32'd1);
    q8.delete();
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale", {31'd0, ov8}, 32'd0);
    end

`ifdef REDUCE_GATE_STATS_EN
    check("stats_cleared", {16'd0, oc8}, 32'd0);
    iv8 = 1; a8 = 8'hFF; m8 = 3'd0;
    repeat (5) tick();
    iv8 = 0;
    drain();
    check("stats_five", {16'd0, oc8}, 32'd5);
    iv8 = 1;
    tick();
    iv8 = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge Clk);
      if (ov8 && or8) begin
        cc8 = 1'b1;
        got = 1'b1;
      end
      tick();
      cc8 = 1'b0;
    end
    check("stats_seen_sixth", {31'd0, got}, 32'd1);
    check("stats_clr_wins", {16'd0, oc8}, 32'd0);
`endif

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
